// File: rtl/upg_boot_ctrl.sv
// Boot/download sequencer: debounces the program button, switches between run and
// UART download mode and routes loader writes to imem/dmem. Optional macro: UPG_TIMEOUT_EN.
module upg_boot_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int RELEASE_DELAY   = 16,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        imem_wen_o,
    output logic        dmem_wen_o,
    output logic [13:0] mem_adr_o,
    output logic [15:0] word_cnt_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RDW = $clog2(RELEASE_DELAY + 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES);
    localparam logic [RDW-1:0] HOLD_LAST = RDW'(RELEASE_DELAY - 1);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
`ifdef UPG_TIMEOUT_EN
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
`endif

    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d;
    logic           press;
    logic [1:0]     state_q, state_d;
    logic [RDW-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]    word_cnt_q, word_cnt_d;
    logic           upg_rst_q, upg_rst_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           in_load;

    // Debounce: counter saturates at DB_MAX; press fires once per debounced rising edge.
    always_comb begin
        db_cnt_d = '0;
        if (sync2_q) begin
            db_cnt_d = (db_cnt_q == DB_MAX) ? DB_MAX : db_cnt_q + 1'b1;
        end
        db_lvl_d = (db_cnt_q == DB_MAX);
        press    = (db_cnt_q == DB_MAX) && !db_lvl_q;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        word_cnt_d = word_cnt_q;
`ifdef UPG_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (press) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (upg_wen_i && (word_cnt_q != 16'hFFFF)) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
`ifdef UPG_TIMEOUT_EN
                if (!upg_wen_i) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                // A completing transfer wins over a timeout in the same cycle.
                if (upg_done_i) begin
                    state_d = S_HOLD;
                end else if (!upg_wen_i && (to_cnt_q == TO_LAST)) begin
                    state_d = S_ERR;
                end
`else
                if (upg_done_i) begin
                    state_d = S_HOLD;
                end
`endif
            end
`ifdef UPG_TIMEOUT_EN
            S_ERR: begin
                if (press) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end
`endif
            default: state_d = S_HOLD;
        endcase

        upg_rst_d = (state_d != S_LOAD);
        cpu_rst_d = (state_d != S_IDLE);
        busy_d    = (state_d == S_LOAD);
`ifdef UPG_TIMEOUT_EN
        err_d     = (state_d == S_ERR);
`else
        err_d     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            db_lvl_q   <= 1'b0;
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            word_cnt_q <= '0;
            upg_rst_q  <= 1'b1;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UPG_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            sync1_q    <= start_pg;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            word_cnt_q <= word_cnt_d;
            upg_rst_q  <= upg_rst_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef UPG_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Write routing is combinational so the loader sees no added latency.
    assign in_load    = (state_q == S_LOAD);
    assign imem_wen_o = in_load && upg_wen_i && !upg_adr_i[14];
    assign dmem_wen_o = in_load && upg_wen_i &&  upg_adr_i[14];
    assign mem_adr_o  = upg_adr_i[13:0];

    assign upg_rst_o  = upg_rst_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_upg_boot_ctrl.sv
// Directed + randomized bench for upg_boot_ctrl with a queue-based reference of the load.
module tb_upg_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pg;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic        upg_done_i;
    logic        upg_rst_o, cpu_rst_o, imem_wen_o, dmem_wen_o, busy_o, err_o;
    logic [13:0] mem_adr_o;
    logic [15:0] word_cnt_o;

    int checks   = 0;
    int failures = 0;

    upg_boot_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RELEASE_DELAY  (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .start_pg   (start_pg),
        .upg_wen_i  (upg_wen_i),
        .upg_adr_i  (upg_adr_i),
        .upg_done_i (upg_done_i),
        .upg_rst_o  (upg_rst_o),
        .cpu_rst_o  (cpu_rst_o),
        .imem_wen_o (imem_wen_o),
        .dmem_wen_o (dmem_wen_o),
        .mem_adr_o  (mem_adr_o),
        .word_cnt_o (word_cnt_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button held long enough: LOAD must appear on the 7th edge after the rise.
    task automatic press_to_load(input string tag);
        start_pg = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) start_pg = 1'b0;
            chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, (k == 7)});
        end
        chk({tag, "_upg_rst"}, {31'd0, upg_rst_o}, 32'd0);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst_o}, 32'd1);
        chk({tag, "_cnt_clr"}, {16'd0, word_cnt_o}, 32'd0);
        repeat (4) tick();
    endtask

    logic [14:0] imem_q[$];
    logic [14:0] dmem_q[$];
    logic [14:0] adr;
    logic        wen;
    logic [14:0] dir_adr[3];

    initial begin
        rst_n = 1'b0; start_pg = 1'b0; upg_wen_i = 1'b0; upg_adr_i = '0; upg_done_i = 1'b0;
        #12;
        chk("rst_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        chk("rst_busy",    {31'd0, busy_o},    32'd0);
        chk("rst_err",     {31'd0, err_o},     32'd0);
        chk("rst_cnt",     {16'd0, word_cnt_o}, 32'd0);

        // Reset release: CPU held for three cycles.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("rel_cpu_rst", {31'd0, cpu_rst_o}, {31'd0, (k < 3)});
            chk("rel_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        end

        // Bounce rejection: 3 high, 3 low, 2 high.
        start_pg = 1'b1; repeat (3) tick();
        start_pg = 1'b0; repeat (3) tick();
        start_pg = 1'b1; repeat (2) tick();
        start_pg = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bounce_busy", {31'd0, busy_o}, 32'd0);
        end
        press_to_load("press1");

        // Directed routing.
        dir_adr[0] = 15'h0005; dir_adr[1] = 15'h4005; dir_adr[2] = 15'h7FFF;
        for (int i = 0; i < 3; i++) begin
            upg_wen_i = 1'b1; upg_adr_i = dir_adr[i];
            #1;
            chk("dir_imem", {31'd0, imem_wen_o}, {31'd0, !dir_adr[i][14]});
            chk("dir_dmem", {31'd0, dmem_wen_o}, {31'd0, dir_adr[i][14]});
            chk("dir_adr",  {18'd0, mem_adr_o},  {18'd0, dir_adr[i][13:0]});
            tick();
            upg_wen_i = 1'b0;
        end
        chk("dir_cnt", {16'd0, word_cnt_o}, 32'd3);

        // Randomized writes against the queue model.
        for (int i = 0; i < 24; i++) begin
            wen = 1'($urandom_range(0, 1));
            adr = 15'($urandom);
            upg_wen_i = wen; upg_adr_i = adr;
            #1;
            chk("rnd_imem", {31'd0, imem_wen_o}, {31'd0, wen && !adr[14]});
            chk("rnd_dmem", {31'd0, dmem_wen_o}, {31'd0, wen && adr[14]});
            chk("rnd_adr",  {18'd0, mem_adr_o},  {18'd0, adr[13:0]});
            if (wen) begin
                if (adr[14]) dmem_q.push_back(adr);
                else         imem_q.push_back(adr);
            end
            tick();
        end
        upg_wen_i = 1'b0;
        chk("rnd_cnt", {16'd0, word_cnt_o}, 32'(3 + imem_q.size() + dmem_q.size()));

        // Simultaneous write and done.
        upg_wen_i = 1'b1; upg_done_i = 1'b1; upg_adr_i = 15'h1234;
        #1;
        chk("wd_imem", {31'd0, imem_wen_o}, 32'd1);
        tick();
        upg_wen_i = 1'b0; upg_done_i = 1'b0;
        chk("wd_cnt",     {16'd0, word_cnt_o}, 32'(4 + imem_q.size() + dmem_q.size()));
        chk("wd_busy",    {31'd0, busy_o},    32'd0);
        chk("wd_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        chk("wd_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("wd_hold", {31'd0, cpu_rst_o}, {31'd0, (k < 3)});
        end

        // Writes outside LOAD are blocked and not counted.
        upg_wen_i = 1'b1; upg_adr_i = 15'h4001;
        #1;
        chk("idle_dmem", {31'd0, dmem_wen_o}, 32'd0);
        upg_adr_i = 15'h0001;
        #1;
        chk("idle_imem", {31'd0, imem_wen_o}, 32'd0);
        tick();
        upg_wen_i = 1'b0;
        chk("idle_cnt", {16'd0, word_cnt_o}, 32'(4 + imem_q.size() + dmem_q.size()));

        // Button held through load and HOLD gives no second press.
        start_pg = 1'b1;
        repeat (7) tick();
        chk("held_load", {31'd0, busy_o}, 32'd1);
        upg_done_i = 1'b1; tick(); upg_done_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("held_nopress", {31'd0, busy_o}, 32'd0);
        end
        chk("held_cpu_run", {31'd0, cpu_rst_o}, 32'd0);
        start_pg = 1'b0;
        repeat (5) tick();

        // Async reset mid-load with ten words written.
        press_to_load("press2");
        upg_wen_i = 1'b1; upg_adr_i = 15'h0100;
        repeat (10) tick();
        upg_wen_i = 1'b0;
        chk("ar_cnt10", {16'd0, word_cnt_o}, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        chk("ar_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        chk("ar_cnt",     {16'd0, word_cnt_o}, 32'd0);
        chk("ar_busy",    {31'd0, busy_o},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("ar_rerun", {31'd0, cpu_rst_o}, 32'd0);

        press_to_load("press3");
`ifdef UPG_TIMEOUT_EN
        // Four idle cycles already elapsed inside press_to_load.
        repeat (45) tick();
        chk("to_before", {31'd0, err_o}, 32'd0);
        tick();
        chk("to_err",     {31'd0, err_o},     32'd1);
        chk("to_busy",    {31'd0, busy_o},    32'd0);
        chk("to_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        chk("to_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        upg_done_i = 1'b1; repeat (2) tick(); upg_done_i = 1'b0;
        chk("to_done_ign", {31'd0, err_o}, 32'd1);
        press_to_load("press_err");
        chk("to_err_clr", {31'd0, err_o}, 32'd0);
`else
        repeat (200) tick();
        chk("nto_busy", {31'd0, busy_o}, 32'd1);
        chk("nto_err",  {31'd0, err_o},  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
